// File: rtl/minimig_zorro_config_ctrl.sv
// Zorro autoconfig chain sequencer: offers present boards one at a time, latches the OS-assigned
// base (or shut-up) per board and decodes registered-base chip selects for configured boards.
module minimig_zorro_config_ctrl #(
  parameter int unsigned NUM_BOARDS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk7_en,
  input  logic [8:1]                address_in,
  input  logic [15:0]               data_in,
  input  logic                      hwr,
  input  logic                      lwr,
  input  logic                      sel,
  input  logic [NUM_BOARDS-1:0]     board_present,
  input  logic [NUM_BOARDS-1:0]     board_z3,
  input  logic [8*NUM_BOARDS-1:0]   board_mask,
  input  logic [31:16]              cpu_addr,
  output logic [2:0]                ac_index,
  output logic                      autoconfig_done,
  output logic [NUM_BOARDS-1:0]     board_configured,
  output logic [NUM_BOARDS-1:0]     board_shutup,
  output logic [16*NUM_BOARDS-1:0]  board_base,
  output logic [NUM_BOARDS-1:0]     board_sel
);

  typedef enum logic [1:0] {StInit, StOffer, StDone} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [3:0]                  pend_lo_q, pend_lo_d;
  logic [NUM_BOARDS-1:0]       configured_q, configured_d;
  logic [NUM_BOARDS-1:0]       shutup_q, shutup_d;
  logic [16*NUM_BOARDS-1:0]    base_q, base_d;

  logic                        wev;
  logic [8:0]                  offset;
  logic [NUM_BOARDS-1:0]       cur_oh;
  logic                        cur_z3;
  logic                        first_found, next_found;
  logic [2:0]                  first_idx, next_idx;
  logic                        advance;
  logic [15:0]                 commit_val;
  logic                        commit;

  assign wev    = clk7_en & sel & (hwr | lwr);
  assign offset = {address_in, 1'b0};

  // Current-board one-hot plus lowest present board overall and above idx.
  always_comb begin
    cur_oh      = '0;
    cur_z3      = 1'b0;
    first_found = 1'b0;
    first_idx   = 3'd0;
    next_found  = 1'b0;
    next_idx    = 3'd0;
    for (int i = 0; i < int'(NUM_BOARDS); i++) begin
      if (3'(i) == idx_q) begin
        cur_oh[i] = 1'b1;
        cur_z3    = board_z3[i];
      end
      if (board_present[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if (board_present[i] && (i > int'(idx_q)) && !next_found) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StInit;
      idx_q        <= 3'd0;
      pend_lo_q    <= 4'd0;
      configured_q <= '0;
      shutup_q     <= '0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_lo_q    <= pend_lo_d;
      configured_q <= configured_d;
      shutup_q     <= shutup_d;
      base_q       <= base_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_lo_d    = pend_lo_q;
    configured_d = configured_q;
    shutup_d     = shutup_q;
    base_d       = base_q;
    advance      = 1'b0;
    commit       = 1'b0;
    commit_val   = 16'h0000;
    unique case (state_q)
      StInit: begin
        if (first_found) begin
          idx_d   = first_idx;
          state_d = StOffer;
        end else begin
          state_d = StDone;
        end
      end
      StOffer: begin
        if (wev) begin
          if (offset == 9'h04C) begin
            shutup_d = shutup_q | cur_oh;
            advance  = 1'b1;
          end else if (!cur_z3 && offset == 9'h04A && hwr) begin
            pend_lo_d = data_in[15:12];
          end else if (!cur_z3 && offset == 9'h048 && hwr) begin
            commit     = 1'b1;
            commit_val = {8'h00, data_in[15:12], pend_lo_q};
          end else if (cur_z3 && offset == 9'h044 && hwr && lwr) begin
            commit     = 1'b1;
            commit_val = data_in;
          end
        end
        if (commit) begin
          configured_d = configured_q | cur_oh;
          advance      = 1'b1;
          for (int i = 0; i < int'(NUM_BOARDS); i++) begin
            if (cur_oh[i]) base_d[16*i +: 16] = commit_val;
          end
        end
        // Advance happens on the commit edge itself; no intermediate state.
        if (advance) begin
          pend_lo_d = 4'd0;
          if (next_found) idx_d = next_idx;
          else            state_d = StDone;
        end
      end
      StDone: ;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    ac_index        = (state_q == StOffer) ? idx_q : 3'b111;
    autoconfig_done = (state_q == StDone);
  end

  assign board_configured = configured_q;
  assign board_shutup     = shutup_q;
  assign board_base       = base_q;

  // Zorro II decodes A23:A16 against base[7:0]; Zorro III decodes A31:A24 against base[15:8].
  for (genvar g = 0; g < int'(NUM_BOARDS); g++) begin : g_sel
    logic [7:0] diff;
    assign diff = board_z3[g] ? (cpu_addr[31:24] ^ base_q[16*g+8 +: 8])
                              : (cpu_addr[23:16] ^ base_q[16*g +: 8]);
    assign board_sel[g] = configured_q[g] & ~shutup_q[g] &
                          ((diff & board_mask[8*g +: 8]) == 8'h00);
  end

endmodule

// File: tb/tb_minimig_zorro_config_ctrl.sv
// Directed self-checking bench for the Zorro autoconfig chain sequencer.
module tb_minimig_zorro_config_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk7_en = 1'b0;
  logic [8:1]  address_in = '0;
  logic [15:0] data_in = '0;
  logic        hwr = 1'b0;
  logic        lwr = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  board_present = '0;
  logic [3:0]  board_z3 = '0;
  logic [31:0] board_mask = 32'hF8F8F8F8;
  logic [31:16] cpu_addr = '0;
  logic [2:0]  ac_index;
  logic        autoconfig_done;
  logic [3:0]  board_configured;
  logic [3:0]  board_shutup;
  logic [63:0] board_base;
  logic [3:0]  board_sel;

  int checks = 0;
  int errors = 0;

  minimig_zorro_config_ctrl #(.NUM_BOARDS(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clk7_en          (clk7_en),
    .address_in       (address_in),
    .data_in          (data_in),
    .hwr              (hwr),
    .lwr              (lwr),
    .sel              (sel),
    .board_present    (board_present),
    .board_z3         (board_z3),
    .board_mask       (board_mask),
    .cpu_addr         (cpu_addr),
    .ac_index         (ac_index),
    .autoconfig_done  (autoconfig_done),
    .board_configured (board_configured),
    .board_shutup     (board_shutup),
    .board_base       (board_base),
    .board_sel        (board_sel)
  );

  always #5 clk = ~clk;

  // Holds reset, then releases on a falling edge; the next rising edge is the INIT cycle.
  task automatic do_reset(input logic [3:0] present, input logic [3:0] z3);
    @(negedge clk);
    reset_n       = 1'b0;
    board_present = present;
    board_z3      = z3;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One bus cycle with the enable high for exactly one rising edge; returns on the next fall.
  task automatic bus_write(input logic [8:0] off, input logic [15:0] d, input logic h,
                           input logic l, input logic en);
    @(negedge clk);
    address_in = off[8:1];
    data_in    = d;
    hwr        = h;
    lwr        = l;
    sel        = 1'b1;
    clk7_en    = en;
    @(negedge clk);
    hwr     = 1'b0;
    lwr     = 1'b0;
    sel     = 1'b0;
    clk7_en = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    board_present = 4'b0101;
    #1;
    checks++;
    if (ac_index !== 3'b111 || autoconfig_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idx: ac_index=%0d done=%0b, want 7/0", ac_index, autoconfig_done);
    end
    checks++;
    if (board_configured !== 4'b0 || board_shutup !== 4'b0 || board_base !== 64'h0 ||
        board_sel !== 4'b0) begin
      errors++;
      $display("FAIL reset_regs: cfg=%b shut=%b base=%h sel=%b, want all 0",
               board_configured, board_shutup, board_base, board_sel);
    end
  endtask

  task automatic test_z2_chain;
    do_reset(4'b0101, 4'b0000);
    checks++;
    if (ac_index !== 3'b111) begin
      errors++;
      $display("FAIL z2_init_idx: ac_index=%0d, want 7", ac_index);
    end
    @(negedge clk);
    checks++;
    if (ac_index !== 3'd0) begin
      errors++;
      $display("FAIL z2_first_offer: ac_index=%0d, want 0", ac_index);
    end
    bus_write(9'h04A, 16'h0000, 1'b1, 1'b0, 1'b1);
    bus_write(9'h048, 16'h2000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_base[15:0] !== 16'h0020 || board_configured !== 4'b0001 || ac_index !== 3'd2) begin
      errors++;
      $display("FAIL z2_commit0: base0=%h cfg=%b idx=%0d, want 0020/0001/2",
               board_base[15:0], board_configured, ac_index);
    end
    bus_write(9'h048, 16'h4000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_base[47:32] !== 16'h0040 || autoconfig_done !== 1'b1 || ac_index !== 3'b111 ||
        board_configured !== 4'b0101) begin
      errors++;
      $display("FAIL z2_commit2: base2=%h done=%0b idx=%0d cfg=%b, want 0040/1/7/0101",
               board_base[47:32], autoconfig_done, ac_index, board_configured);
    end
    cpu_addr = 16'h0021;
    #1;
    checks++;
    if (board_sel !== 4'b0001) begin
      errors++;
      $display("FAIL z2_sel0: board_sel=%b, want 0001", board_sel);
    end
    cpu_addr = 16'h0041;
    #1;
    checks++;
    if (board_sel !== 4'b0100) begin
      errors++;
      $display("FAIL z2_sel2: board_sel=%b, want 0100", board_sel);
    end
    bus_write(9'h04C, 16'h0000, 1'b1, 1'b1, 1'b1);
    checks++;
    if (board_shutup !== 4'b0000 || autoconfig_done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores: shut=%b done=%0b, want 0000/1", board_shutup, autoconfig_done);
    end
  endtask

  task automatic test_z3;
    do_reset(4'b0001, 4'b0001);
    @(negedge clk);
    bus_write(9'h048, 16'h1000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_configured !== 4'b0000 || ac_index !== 3'd0) begin
      errors++;
      $display("FAIL z3_ignore48: cfg=%b idx=%0d, want 0000/0", board_configured, ac_index);
    end
    bus_write(9'h044, 16'h4000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_configured !== 4'b0000 || ac_index !== 3'd0) begin
      errors++;
      $display("FAIL z3_hwr_only: cfg=%b idx=%0d, want 0000/0", board_configured, ac_index);
    end
    bus_write(9'h044, 16'h4000, 1'b1, 1'b1, 1'b1);
    cpu_addr = 16'h4012;
    #1;
    checks++;
    if (board_base[15:0] !== 16'h4000 || autoconfig_done !== 1'b1 || ac_index !== 3'b111 ||
        board_sel !== 4'b0001) begin
      errors++;
      $display("FAIL z3_commit: base0=%h done=%0b idx=%0d sel=%b, want 4000/1/7/0001",
               board_base[15:0], autoconfig_done, ac_index, board_sel);
    end
    cpu_addr = 16'h5012;
    #1;
    checks++;
    if (board_sel !== 4'b0000) begin
      errors++;
      $display("FAIL z3_sel_miss: board_sel=%b, want 0000", board_sel);
    end
  endtask

  task automatic test_shutup;
    do_reset(4'b0011, 4'b0000);
    @(negedge clk);
    bus_write(9'h04A, 16'h7000, 1'b1, 1'b0, 1'b1);
    bus_write(9'h04C, 16'h0000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (board_shutup !== 4'b0000 || ac_index !== 3'd0) begin
      errors++;
      $display("FAIL no_clk7_en: shut=%b idx=%0d, want 0000/0", board_shutup, ac_index);
    end
    bus_write(9'h04C, 16'h0000, 1'b0, 1'b1, 1'b1);
    cpu_addr = 16'h0000;
    #1;
    checks++;
    if (board_shutup !== 4'b0001 || board_configured !== 4'b0000 || ac_index !== 3'd1 ||
        board_sel[0] !== 1'b0) begin
      errors++;
      $display("FAIL shutup: shut=%b cfg=%b idx=%0d sel0=%b, want 0001/0000/1/0",
               board_shutup, board_configured, ac_index, board_sel[0]);
    end
    // pend_lo was loaded with 7 on board 0 and must have cleared on the shut-up advance.
    bus_write(9'h048, 16'h3000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_base[31:16] !== 16'h0030 || board_configured !== 4'b0010 ||
        autoconfig_done !== 1'b1) begin
      errors++;
      $display("FAIL pend_clear: base1=%h cfg=%b done=%0b, want 0030/0010/1",
               board_base[31:16], board_configured, autoconfig_done);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(4'b0111, 4'b0000);
    @(negedge clk);
    address_in = 8'h26;
    hwr        = 1'b1;
    sel        = 1'b1;
    clk7_en    = 1'b1;
    @(negedge clk);
    clk7_en = 1'b0;
    repeat (2) @(negedge clk);
    hwr = 1'b0;
    sel = 1'b0;
    checks++;
    if (board_shutup !== 4'b0001 || ac_index !== 3'd1) begin
      errors++;
      $display("FAIL held_strobe: shut=%b idx=%0d, want 0001/1", board_shutup, ac_index);
    end
  endtask

  task automatic test_none_present;
    do_reset(4'b0000, 4'b0000);
    checks++;
    if (autoconfig_done !== 1'b0) begin
      errors++;
      $display("FAIL none_pre: done=%0b, want 0", autoconfig_done);
    end
    @(negedge clk);
    checks++;
    if (autoconfig_done !== 1'b1 || ac_index !== 3'b111) begin
      errors++;
      $display("FAIL none_done: done=%0b idx=%0d, want 1/7", autoconfig_done, ac_index);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(4'b0011, 4'b0000);
    @(negedge clk);
    bus_write(9'h048, 16'h2000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (board_configured !== 4'b0001 || ac_index !== 3'd1) begin
      errors++;
      $display("FAIL mid_commit: cfg=%b idx=%0d, want 0001/1", board_configured, ac_index);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (board_configured !== 4'b0 || board_base !== 64'h0 || ac_index !== 3'b111 ||
        autoconfig_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cfg=%b base=%h idx=%0d done=%0b, want 0/0/7/0",
               board_configured, board_base, ac_index, autoconfig_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ac_index !== 3'd0) begin
      errors++;
      $display("FAIL restart: ac_index=%0d, want 0", ac_index);
    end
  endtask

  initial begin
    test_reset();
    test_z2_chain();
    test_z3();
    test_shutup();
    test_back_to_back();
    test_none_present();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minimig_zorro_config_ctrl.md
# minimig_zorro_config_ctrl

Sequencer for the Zorro autoconfig chain in the $E80000 window. It offers up to four boards to the OS one at a time and drives the board index used by the autoconfig ROM lookup. It latches the base address the OS writes for each board, handles shut-up, and produces registered-base chip selects for configured boards. It sits between the CPU bus decode (`sel` = autoconfig window) and the per-board RAM/peripheral selects.

## Interface
Parameters:
- `NUM_BOARDS`, 4: chain length; `ac_index` is 3 bits regardless of this value.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `clk7_en` in 1: CPU bus qualifier. Writes are acted on only when it is high.
- `address_in` in 8 [8:1]: CPU word address within the autoconfig window.
- `data_in` in 16: CPU write data.
- `hwr` in 1: high-byte write strobe.
- `lwr` in 1: low-byte write strobe.
- `sel` in 1: autoconfig window select.
- `board_present` in NUM_BOARDS: per-slot enable. Sampled only at INIT and at each advance.
- `board_z3` in NUM_BOARDS: 1 = Zorro III board, 0 = Zorro II board.
- `board_mask` in 8*NUM_BOARDS: per-board compare mask on the decoded address byte. Bit = 1 means compare.
- `cpu_addr` in 16 [31:16]: CPU address for the select decode.
- `ac_index` out 3: board currently offered to the ROM. 3'b111 = null board.
- `autoconfig_done` out 1: chain exhausted.
- `board_configured` out NUM_BOARDS: base committed.
- `board_shutup` out NUM_BOARDS: board shut up by the OS.
- `board_base` out 16*NUM_BOARDS: committed A31:A16 per board. Zorro II boards use bits [7:0] = A23:A16 and hold [15:8] = 0.
- `board_sel` out NUM_BOARDS: combinational chip select.

## Operation
- A write event `wev` is `clk7_en & sel & (hwr|lwr)`. The offset is `{address_in,1'b0}`.
- The FSM has three states: INIT, OFFER and DONE.
- **INIT** (one clk after `reset_n` deasserts):
  - `idx` is set to the lowest i with `board_present[i]`, and the FSM goes to OFFER.
  - If no board is present, the FSM goes to DONE.
- **OFFER**, board `idx`. `ac_index = idx`. The following events apply:
  - **Zorro II, offset $4A with `hwr`:** `pend_lo <= data_in[15:12]`.
  - **Zorro II, offset $48 with `hwr`:**
    - `board_base[idx] <= {8'h00, data_in[15:12], pend_lo}`.
    - `board_configured[idx] <= 1`.
    - Advance.
  - **Zorro III, offset $48:** ignored, whether it arrives before or after the commit.
  - **Zorro III, offset $44 with `hwr & lwr`:**
    - `board_base[idx] <= data_in`.
    - `board_configured[idx] <= 1`.
    - Advance.
    - With only `hwr` or only `lwr`, the write is ignored.
  - **Offset $4C with any strobe:**
    - `board_shutup[idx] <= 1`.
    - `board_configured[idx]` is unchanged (stays 0).
    - Advance.
  - **Any other offset:** no effect.
- **Advance:** `idx` moves to the lowest i > `idx` with `board_present[i]`. This happens on the same edge as the commit, with no intermediate state. If there is no such i, the FSM goes to DONE.
- **DONE:**
  - `ac_index = 3'b111` and `autoconfig_done = 1`.
  - All writes are ignored until reset.
- **`pend_lo`** clears to 0 on every advance.
- **Select decode:**
  - For a Zorro II board: `board_sel[i] = board_configured[i] & ((cpu_addr[23:16] ^ board_base[i][7:0]) & mask_i) == 0`.
  - For a Zorro III board: the same equation, but comparing `cpu_addr[31:24]` against `board_base[i][15:8]`.
  - Shut-up boards never select.

## Timing
- **Reset values:**
  - `ac_index = 3'b111`.
  - `autoconfig_done = 0`.
  - `board_configured`, `board_shutup`, `board_base`, `pend_lo` all 0.
  - State = INIT.
- **Latency:**
  - The first board is offered 1 clk after reset release.
  - A commit, shut-up, advance or DONE transition is visible on the clk edge of the qualifying write.
  - The new `ac_index` is valid on the following cycle.
- **Repeated writes:** a write held for several `clk` with `clk7_en` high only once acts only on the first qualifying edge. The block does not debounce multi-cycle strobes with `clk7_en` high; the bus guarantees one enable per access.
- **Reset mid-chain:** all state is cleared asynchronously, and the chain restarts at INIT.
- **Simultaneous strobes:** `hwr & lwr` at $48/$4A/$4C is treated as a single write.
- **Last board:** an advance from the last present board goes to DONE in the same edge.

## Test plan
- Present 4'b0101, all Zorro II, masks 8'hF8. Write $4A data 16'h0000, then $48 data 16'h2000. Required: base0 = 16'h0020, configured = 4'b0001, `ac_index` 0→2. Then write $48 data 16'h4000. Required: base2 = 16'h0040, DONE, `ac_index` = 7.
- `board_z3` = 4'b0001, present 4'b0001. Write $48 data 16'h1000, then $44 data 16'h4000 with both strobes. Required: the $48 write is ignored, base0 = 16'h4000, DONE, and `board_sel` = 1 for `cpu_addr` = 16'h4012.
- Present 4'b0011. Write $4C. Required: shutup = 4'b0001, configured = 0, `ac_index` = 1, and `board_sel[0]` never asserts.
- Zorro III $44 write with `hwr` only. Required: no commit, and `ac_index` unchanged.
- Present 4'b0000. Required: DONE 1 clk after reset release, `ac_index` = 7.
- Assert `reset_n` low after board 0 has committed. Required: all outputs return to their reset values immediately (asynchronously), and board 0 is offered again after release.
